mul_issue_stage: RTL and testbench

Sequential issue/retire stage that sits directly upstream and downstream of the combinational `Multiplication` array in the ALU datapath. It accepts operands over a valid/ready handshake and converts signed operands to magnitudes. It drives them into the unsigned array and waits a fixed number of settle cycles, which makes the array a registered multicycle path. It then sign-corrects the low half of the product, computes signed or unsigned overflow, and holds the result until the consumer takes it.

---
 rtl/mul_issue_stage.sv | 115 +++++++++++
 tb/tb_mul_issue_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_stage.sv
// Issue/retire stage around the combinational unsigned multiplier array: takes operands,
// feeds magnitudes to the array, waits SETTLE cycles, then sign-corrects and flags overflow.
module mul_issue_stage #(
   parameter int l      = 16,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [l-1:0] op_a,
   input  logic [l-1:0] op_b,
   input  logic         is_signed,
   output logic [l-1:0] mul_a,
   output logic [l-1:0] mul_b,
   input  logic [l-1:0] mul_r,
   input  logic         mul_ovf,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [l-1:0] result,
   output logic         overflow,
   output logic [1:0]   o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // the producer holds data while ready is 0, and outputs stay frozen until taken.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0]   CNT_INIT = 4'(SETTLE - 1);
   localparam logic [l-1:0] ONE      = {{(l-1){1'b0}}, 1'b1};
   localparam logic [l-1:0] HALF     = {1'b1, {(l-1){1'b0}}};

   state_t       r_state;
   state_t       w_next;
   logic [3:0]   r_cnt;
   logic         r_neg;
   logic         r_signed;
   logic [l-1:0] r_mul_a;
   logic [l-1:0] r_mul_b;
   logic [l-1:0] r_result;
   logic         r_overflow;

   logic         w_accept;
   logic         w_finish;
   logic [l-1:0] w_abs_a;
   logic [l-1:0] w_abs_b;
   logic         w_neg_in;
   logic [l-1:0] w_res;
   logic         w_ovf;

   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign w_finish = (r_state == S_SETTLE) && (r_cnt == 4'd0);

   // The most negative value maps to HALF, which is its exact unsigned magnitude.
   assign w_abs_a  = (is_signed && op_a[l-1]) ? (~op_a + ONE) : op_a;
   assign w_abs_b  = (is_signed && op_b[l-1]) ? (~op_b + ONE) : op_b;
   assign w_neg_in = is_signed & (op_a[l-1] ^ op_b[l-1]);

   assign w_res = r_neg ? (~mul_r + ONE) : mul_r;
   assign w_ovf = mul_ovf | (r_signed & (r_neg ? (mul_r > HALF) : mul_r[l-1]));

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (in_valid)        w_next = S_SETTLE;
         S_SETTLE: if (r_cnt == 4'd0)   w_next = S_DONE;
         S_DONE:   if (out_ready)       w_next = S_IDLE;
         default:                       w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= 4'd0;
         r_neg      <= 1'b0;
         r_signed   <= 1'b0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt    <= CNT_INIT;
            r_neg    <= w_neg_in;
            r_signed <= is_signed;
            r_mul_a  <= w_abs_a;
            r_mul_b  <= w_abs_b;
         end else if ((r_state == S_SETTLE) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_finish) begin
            r_result   <= w_res;
            r_overflow <= w_ovf;
         end
      end
   end

   assign in_ready    = (r_state == S_IDLE);
   assign out_valid   = (r_state == S_DONE);
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign result      = r_result;
   assign overflow    = r_overflow;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_issue_stage.sv
// Bench for mul_issue_stage: three builds (SETTLE = 2, 1, 4) each wrapped with a
// behavioural model of the unsigned multiplier array; results checked via an expected queue.
module tb_mul_issue_stage;

   localparam int N = 3;

   logic        clk;
   logic        reset;
   logic        in_valid  [N];
   logic        in_ready  [N];
   logic [15:0] op_a      [N];
   logic [15:0] op_b      [N];
   logic        is_signed [N];
   logic [15:0] mul_a     [N];
   logic [15:0] mul_b     [N];
   logic [15:0] mul_r     [N];
   logic        mul_ovf   [N];
   logic        out_valid [N];
   logic        out_ready [N];
   logic [15:0] result    [N];
   logic        overflow  [N];
   logic [1:0]  dbg_state [N];
   logic [31:0] prod      [N];

   int st_of [N] = '{2, 1, 4};

   // Expected entries: {overflow, result}; only one build is active at a time.
   logic [16:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   for (genvar k = 0; k < N; k++) begin : g_dut
      mul_issue_stage #(.l(16), .SETTLE((k == 0) ? 2 : ((k == 1) ? 1 : 4))) dut (
         .clk(clk), .reset(reset),
         .in_valid(in_valid[k]), .in_ready(in_ready[k]),
         .op_a(op_a[k]), .op_b(op_b[k]), .is_signed(is_signed[k]),
         .mul_a(mul_a[k]), .mul_b(mul_b[k]),
         .mul_r(mul_r[k]), .mul_ovf(mul_ovf[k]),
         .out_valid(out_valid[k]), .out_ready(out_ready[k]),
         .result(result[k]), .overflow(overflow[k]),
         .o_dbg_state(dbg_state[k])
      );
      assign prod[k]    = 32'(mul_a[k]) * 32'(mul_b[k]);
      assign mul_r[k]   = prod[k][15:0];
      assign mul_ovf[k] = |prod[k][31:16];
   end

   // Clock / reset / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish obs=timeout exp=finish");
      $fatal(1);
   end

   function automatic logic [16:0] model(logic [15:0] a, logic [15:0] b, logic s);
      longint p;
      logic   ovf;
      if (s) begin
         p   = longint'($signed(a)) * longint'($signed(b));
         ovf = (p > 32767) || (p < -32768);
      end else begin
         p   = longint'(a) * longint'(b);
         ovf = (p > 65535);
      end
      return {ovf, p[15:0]};
   endfunction

   function automatic logic [15:0] mag(logic [15:0] x, logic s);
      return (s && x[15]) ? 16'(-x) : x;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver: called at a negedge; returns #1 after the accept edge.
   task automatic issue(int k, logic [15:0] a, logic [15:0] b, logic s, bit push);
      int n = 0;
      op_a[k] = a; op_b[k] = b; is_signed[k] = s; in_valid[k] = 1'b1;
      if (push) exp_q.push_back(model(a, b, s));
      while (!in_ready[k] && n < 50) begin
         @(negedge clk); n++;
      end
      chk("issue_ready", 32'(in_ready[k]), 32'd1);
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
   endtask

   // Edges counted from the accept edge (inclusive) to the edge raising out_valid.
   task automatic wait_out(int k, output int lat);
      lat = 1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid[k]) break;
         lat++;
      end
      chk("out_valid_seen", 32'(out_valid[k]), 32'd1);
   endtask

   task automatic finish_op(int k, string tag);
      int          lat;
      logic [16:0] e;
      wait_out(k, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(st_of[k] + 1));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1_dead;
      chk({tag, "_res"}, 32'(result[k]), 32'(e[15:0]));
      chk({tag, "_ovf"}, 32'(overflow[k]), 32'(e[16]));
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, 32'(in_ready[k]), 32'd1);
   endtask

   task automatic run_op(int k, logic [15:0] a, logic [15:0] b, logic s, string tag);
      issue(k, a, b, s, 1'b1);
      finish_op(k, tag);
   endtask

   // Back-to-back: in_valid and out_ready held high; three accepts must be SETTLE+2 apart.
   task automatic b2b(int k, string tag);
      int          acc[3];
      int          n = 0;
      int          nout = 0;
      logic [16:0] e;
      op_a[k] = 16'd7; op_b[k] = 16'hFFF7; is_signed[k] = 1'b1;
      in_valid[k] = 1'b1; out_ready[k] = 1'b1;
      for (int c = 0; c < 80 && nout < 3; c++) begin
         if (n == 3) in_valid[k] = 1'b0;
         if (out_valid[k]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1_dead;
            chk({tag, "_res"}, 32'(result[k]), 32'(e[15:0]));
            chk({tag, "_ovf"}, 32'(overflow[k]), 32'(e[16]));
            nout++;
         end
         if (in_ready[k] && in_valid[k]) begin
            exp_q.push_back(model(op_a[k], op_b[k], 1'b1));
            acc[n] = c;
            n++;
         end
         @(negedge clk);
      end
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      chk({tag, "_nout"}, 32'(nout), 32'd3);
      chk({tag, "_gap1"}, 32'(acc[1] - acc[0]), 32'(st_of[k] + 2));
      chk({tag, "_gap2"}, 32'(acc[2] - acc[1]), 32'(st_of[k] + 2));
   endtask

   initial begin
      logic [16:0] ea;
      int          lat;
      int          rises;
      logic [15:0] ra, rb;
      logic        rs;

      for (int k = 0; k < N; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         op_a[k] = '0; op_b[k] = '0; is_signed[k] = 1'b0;
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
      chk("rst_mul_a", 32'(mul_a[0]), 32'd0);
      chk("rst_mul_b", 32'(mul_b[0]), 32'd0);
      chk("rst_result", 32'(result[0]), 32'd0);
      chk("rst_overflow", 32'(overflow[0]), 32'd0);
      chk("rst_state", 32'(dbg_state[0]), 32'd0);

      // Signed -3 x 5: magnitudes appear on the array inputs right after accept
      issue(0, 16'hFFFD, 16'h0005, 1'b1, 1'b1);
      chk("m3x5_mul_a", 32'(mul_a[0]), 32'd3);
      chk("m3x5_mul_b", 32'(mul_b[0]), 32'd5);
      finish_op(0, "m3x5");

      run_op(0, 16'd300, 16'd300, 1'b0, "u300x300");
      run_op(0, 16'd255, 16'd257, 1'b0, "u255x257");
      run_op(0, 16'h8000, 16'h0001, 1'b1, "smin_x1");
      run_op(0, 16'h8000, 16'hFFFF, 1'b1, "smin_xm1");
      run_op(0, 16'd256, 16'd128, 1'b1, "s256x128");
      run_op(0, 16'hFF00, 16'd128, 1'b1, "sm256x128");
      run_op(0, 16'd0, 16'hFFF9, 1'b1, "s0xm7");
      run_op(0, 16'h8000, 16'h8000, 1'b0, "u8000sq");
      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         if (i < 3) begin
            ra = ra >> $urandom_range(6, 14);
            rb = rb >> $urandom_range(6, 14);
         end
         rs = 1'($urandom_range(0, 1));
         run_op(0, ra, rb, rs, "rand");
      end

      // Backpressure: held result while a second operand waits with in_valid high
      issue(0, 16'd1234, 16'd5, 1'b0, 1'b1);
      wait_out(0, lat);
      chk("bp_lat", 32'(lat), 32'(st_of[0] + 1));
      ea = exp_q.pop_front();
      op_a[0] = 16'hFFF0; op_b[0] = 16'd3; is_signed[0] = 1'b1; in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_res", 32'(result[0]), 32'(ea[15:0]));
         chk("bp_hold_ovf", 32'(overflow[0]), 32'(ea[16]));
         chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
         chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      end
      exp_q.push_back(model(16'hFFF0, 16'd3, 1'b1));
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      @(negedge clk);
      chk("bp_ready_after", 32'(in_ready[0]), 32'd1);
      chk("bp_valid_after", 32'(out_valid[0]), 32'd0);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      chk("bp_second_acc", 32'(in_ready[0]), 32'd0);
      chk("bp_second_mula", 32'(mul_a[0]), 32'(mag(16'hFFF0, 1'b1)));
      finish_op(0, "bp_second");

      // Reset one cycle after accept abandons the operation
      issue(0, 16'd100, 16'd3, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      rises = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid[0]) rises++;
      end
      chk("rst_mid_no_valid", 32'(rises), 32'd0);
      chk("rst_mid_result", 32'(result[0]), 32'd0);
      chk("rst_mid_ovf", 32'(overflow[0]), 32'd0);
      chk("rst_mid_mul_a", 32'(mul_a[0]), 32'd0);
      chk("rst_mid_ready", 32'(in_ready[0]), 32'd1);
      run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, "after_rst");

      // SETTLE = 1 and SETTLE = 4 builds
      run_op(1, 16'hFFFD, 16'h0005, 1'b1, "s1_op");
      run_op(2, 16'd300, 16'd300, 1'b0, "s4_op");
      b2b(1, "s1_b2b");
      b2b(2, "s4_b2b");
      b2b(0, "s2_b2b");

      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
